// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: registered one-hot bus grant with fixed-priority or
// round-robin selection. The grant passes between masters with no idle
// cycle, and a bounded tenure forces the holder off the bus when another
// master is waiting.
module bus_arbiter_rr #(
    parameter int NMASTERS = 2,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 8,
    localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NMASTERS-1:0] req,
    output logic [NMASTERS-1:0] gnt,
    output logic [IW-1:0]       gnt_idx,
    output logic                busy,
    output logic                preempt
);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    localparam logic [7:0]    HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_RESET = IW'(NMASTERS - 1);

    state_t              state;
    state_t              next_state;
    logic [IW-1:0]       holder;
    logic [IW-1:0]       next_holder;
    logic [IW-1:0]       last;
    logic [IW-1:0]       next_last;
    logic [7:0]          count;
    logic [7:0]          next_count;
    logic                next_preempt;
    logic [NMASTERS-1:0] next_gnt;
    logic [IW-1:0]       next_gnt_idx;
    logic                next_busy;

    logic [NMASTERS-1:0] mask;
    logic [NMASTERS-1:0] cand;
    logic                win_found;
    logic [IW-1:0]       win_idx;

    // State register: all state and every output is a flop; reset overrides req.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            holder  <= '0;
            last    <= LAST_RESET;
            count   <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state   <= next_state;
            holder  <= next_holder;
            last    <= next_last;
            count   <= next_count;
            gnt     <= next_gnt;
            gnt_idx <= next_gnt_idx;
            busy    <= next_busy;
            preempt <= next_preempt;
        end
    end

    // Winner selection: the current holder is masked out so that a handoff or
    // forced release always moves the bus to a different master.
    always_comb begin : arb_select
        int base;
        int pos;
        mask = '1;
        if (state == GRANTED) begin
            mask[holder] = 1'b0;
        end
        cand      = req & mask;
        win_found = 1'b0;
        win_idx   = '0;
        base      = (RR_MODE != 0) ? int'(last) + 1 : 0;
        pos       = 0;
        for (int k = 0; k < NMASTERS; k++) begin
            pos = base + k;
            if (pos >= NMASTERS) begin
                pos = pos - NMASTERS;
            end
            if (!win_found && cand[pos[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[IW-1:0];
            end
        end
    end

    // Next-state logic: grant from idle, handoff on release, forced release at
    // the tenure limit, otherwise hold with a saturating tenure counter.
    always_comb begin
        next_state   = state;
        next_holder  = holder;
        next_last    = last;
        next_count   = count;
        next_preempt = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    next_state  = GRANTED;
                    next_holder = win_idx;
                    next_last   = win_idx;
                    next_count  = 8'd1;
                end
            end
            GRANTED: begin
                if (!req[holder]) begin
                    if (win_found) begin
                        next_holder = win_idx;
                        next_last   = win_idx;
                        next_count  = 8'd1;
                    end else begin
                        next_state  = IDLE;
                        next_holder = '0;
                        next_count  = 8'd0;
                    end
                end else if ((HOLD_LIMIT != 8'd0) && (count == HOLD_LIMIT) && win_found) begin
                    next_holder  = win_idx;
                    next_last    = win_idx;
                    next_count   = 8'd1;
                    next_preempt = 1'b1;
                end else if (count < HOLD_LIMIT) begin
                    next_count = count + 8'd1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode of the next state, so gnt, gnt_idx and busy are always
    // registered together and stay mutually consistent.
    always_comb begin
        next_gnt     = '0;
        next_gnt_idx = '0;
        next_busy    = 1'b0;
        if (next_state == GRANTED) begin
            next_gnt[next_holder] = 1'b1;
            next_gnt_idx          = next_holder;
            next_busy             = 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed bench driving three arbiter variants
// (round-robin without tenure limit, fixed priority with limit 4,
// round-robin with limit 4) and scoring every cycle against a queue of
// expected grants.
module tb_bus_arbiter_rr;

    typedef struct {
        int         dut;
        logic [3:0] gnt;
        logic       pre;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_rr, req_fx, req_rh;
    logic [3:0] gnt_rr, gnt_fx, gnt_rh;
    logic [1:0] idx_rr, idx_fx, idx_rh;
    logic       busy_rr, busy_fx, busy_rh;
    logic       pre_rr, pre_fx, pre_rh;

    exp_t  exp_q[$];
    string tag_q[$];
    int    compares   = 0;
    int    mismatches = 0;

    bus_arbiter_rr #(.NMASTERS(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .reset(reset), .req(req_rr), .gnt(gnt_rr),
        .gnt_idx(idx_rr), .busy(busy_rr), .preempt(pre_rr)
    );

    bus_arbiter_rr #(.NMASTERS(4), .RR_MODE(0), .MAX_HOLD(4)) u_fx (
        .clk(clk), .reset(reset), .req(req_fx), .gnt(gnt_fx),
        .gnt_idx(idx_fx), .busy(busy_fx), .preempt(pre_fx)
    );

    bus_arbiter_rr #(.NMASTERS(4), .RR_MODE(1), .MAX_HOLD(4)) u_rh (
        .clk(clk), .reset(reset), .req(req_rh), .gnt(gnt_rh),
        .gnt_idx(idx_rh), .busy(busy_rh), .preempt(pre_rh)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) begin
            if (g[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic checkOutput();
        exp_t       e;
        string      tag;
        logic [3:0] g;
        logic [1:0] gi;
        logic       b;
        logic       p;
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        case (e.dut)
            0:       begin g = gnt_rr; gi = idx_rr; b = busy_rr; p = pre_rr; end
            1:       begin g = gnt_fx; gi = idx_fx; b = busy_fx; p = pre_fx; end
            default: begin g = gnt_rh; gi = idx_rh; b = busy_rh; p = pre_rh; end
        endcase
        compares++;
        assert (g === e.gnt) else begin
            mismatches++;
            $error("[TB] FAIL %s gnt observed=%b expected=%b", tag, g, e.gnt);
        end
        compares++;
        assert (gi === idx_of(e.gnt)) else begin
            mismatches++;
            $error("[TB] FAIL %s gnt_idx observed=%0d expected=%0d", tag, gi, idx_of(e.gnt));
        end
        compares++;
        assert (b === (|e.gnt)) else begin
            mismatches++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, b, |e.gnt);
        end
        compares++;
        assert (p === e.pre) else begin
            mismatches++;
            $error("[TB] FAIL %s preempt observed=%b expected=%b", tag, p, e.pre);
        end
    endtask

    task automatic applyStimulus(input int d, input logic rst, input logic [3:0] r,
                                 input logic [3:0] eg, input logic ep, input string tag);
        exp_t e;
        reset = rst;
        case (d)
            0:       req_rr = r;
            1:       req_fx = r;
            default: req_rh = r;
        endcase
        e.dut = d;
        e.gnt = eg;
        e.pre = ep;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        req_rr = 4'b1111;
        req_fx = 4'b1111;
        req_rh = 4'b1111;
        $display("[TB] reset and idle");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 4'b1111, 4'b0000, 1'b0, "reset_hold");
        req_fx = 4'b0000;
        req_rh = 4'b0000;
        applyStimulus(0, 1'b0, 4'b1111, 4'b0001, 1'b0, "reset_release");

        $display("[TB] round-robin rotation");
        applyStimulus(0, 1'b0, 4'b1111, 4'b0001, 1'b0, "rr_m0_hold");
        applyStimulus(0, 1'b0, 4'b1110, 4'b0010, 1'b0, "rr_to_m1");
        applyStimulus(0, 1'b0, 4'b1111, 4'b0010, 1'b0, "rr_m1_hold");
        applyStimulus(0, 1'b0, 4'b1101, 4'b0100, 1'b0, "rr_to_m2");
        applyStimulus(0, 1'b0, 4'b1111, 4'b0100, 1'b0, "rr_m2_hold");
        applyStimulus(0, 1'b0, 4'b1011, 4'b1000, 1'b0, "rr_to_m3");
        applyStimulus(0, 1'b0, 4'b1111, 4'b1000, 1'b0, "rr_m3_hold");
        applyStimulus(0, 1'b0, 4'b0111, 4'b0001, 1'b0, "rr_wrap_m0");
        applyStimulus(0, 1'b0, 4'b0000, 4'b0000, 1'b0, "rr_idle");

        $display("[TB] fixed priority");
        applyStimulus(1, 1'b0, 4'b1010, 4'b0010, 1'b0, "fx_m1_first");
        applyStimulus(1, 1'b0, 4'b1010, 4'b0010, 1'b0, "fx_m1_hold");
        applyStimulus(1, 1'b0, 4'b1000, 4'b1000, 1'b0, "fx_to_m3");
        applyStimulus(1, 1'b0, 4'b1010, 4'b1000, 1'b0, "fx_m1_waits");
        applyStimulus(1, 1'b0, 4'b1010, 4'b1000, 1'b0, "fx_m1_waits2");
        applyStimulus(1, 1'b0, 4'b0010, 4'b0010, 1'b0, "fx_back_m1");
        applyStimulus(1, 1'b0, 4'b0000, 4'b0000, 1'b0, "fx_idle");

        $display("[TB] fixed priority with forced release");
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, 4'b0011, 4'b0001, 1'b0, "fxh_m0_tenure");
        applyStimulus(1, 1'b0, 4'b0011, 4'b0010, 1'b1, "fxh_force_m1");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1'b0, 4'b0011, 4'b0010, 1'b0, "fxh_m1_tenure");
        applyStimulus(1, 1'b0, 4'b0011, 4'b0001, 1'b1, "fxh_force_m0");
        applyStimulus(1, 1'b0, 4'b0000, 4'b0000, 1'b0, "fxh_idle");

        $display("[TB] round-robin forced release");
        applyStimulus(2, 1'b0, 4'b0100, 4'b0100, 1'b0, "fr_m2_c1");
        applyStimulus(2, 1'b0, 4'b0100, 4'b0100, 1'b0, "fr_m2_c2");
        applyStimulus(2, 1'b0, 4'b0101, 4'b0100, 1'b0, "fr_m2_c3");
        applyStimulus(2, 1'b0, 4'b0101, 4'b0100, 1'b0, "fr_m2_c4");
        applyStimulus(2, 1'b0, 4'b0101, 4'b0001, 1'b1, "fr_force_m0");
        applyStimulus(2, 1'b0, 4'b0101, 4'b0001, 1'b0, "fr_m0_hold");
        applyStimulus(2, 1'b0, 4'b0100, 4'b0100, 1'b0, "fr_back_m2");
        applyStimulus(2, 1'b0, 4'b0000, 4'b0000, 1'b0, "fr_idle");

        $display("[TB] no competitor");
        for (int i = 0; i < 20; i++) applyStimulus(2, 1'b0, 4'b1000, 4'b1000, 1'b0, "solo_m3");
        applyStimulus(2, 1'b0, 4'b1010, 4'b0010, 1'b1, "solo_late_m1");
        applyStimulus(2, 1'b0, 4'b0010, 4'b0010, 1'b0, "solo_m1_hold");

        $display("[TB] reset mid-tenure");
        applyStimulus(2, 1'b0, 4'b0100, 4'b0100, 1'b0, "mid_m2");
        applyStimulus(2, 1'b1, 4'b0100, 4'b0000, 1'b0, "mid_reset");
        applyStimulus(2, 1'b0, 4'b0110, 4'b0010, 1'b0, "mid_after_m1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
